// File: rtl/iob_cpu_bus_arbiter_pkg.sv
// Shared encodings for the CPU bus arbiter: FSM states, grant identifiers
// and the byte-strobe width helper.
package iob_cpu_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic GNT_IBUS = 1'b0;
  localparam logic GNT_DBUS = 1'b1;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/iob_rr_arb2.sv
// Combinational two-requester arbiter: req[0] is ibus, req[1] is dbus.
// A tie goes to dbus in priority mode, otherwise to the side not granted last.
module iob_rr_arb2
  import iob_cpu_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio_mode,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = GNT_IBUS;
    if (req == 2'b11) begin
      gnt_idx = prio_mode ? GNT_DBUS : ~last;
    end else if (req[1]) begin
      gnt_idx = GNT_DBUS;
    end
  end

endmodule

// File: rtl/iob_cpu_bus_arbiter.sv
// Merges the CPU instruction and data buses onto one IOb-native memory port,
// one outstanding transaction at a time, with a watchdog on the memory side.
module iob_cpu_bus_arbiter
  import iob_cpu_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DBUS_PRIO = 0,
  parameter int TIMEOUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_ready,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_valid,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_ready,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_ready,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  timeout
);

  localparam int STRB_W = strb_w(DATA_W);
  // The counter holds BUSY cycles already spent, so firing one below
  // all-ones caps m_valid at 2**TIMEOUT_W-1 cycles.
  localparam logic [TIMEOUT_W-1:0] WDOG_FIRE = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);
  localparam logic PRIO_MODE = (DBUS_PRIO != 0);

  state_t               state;
  state_t               state_d;
  logic                 gnt;
  logic                 last_grant;
  logic [TIMEOUT_W-1:0] wdog;
  logic                 arb_vld;
  logic                 arb_idx;
  logic                 req_done;
  logic                 req_tout;
  logic [DATA_W-1:0]    resp_data;

  iob_rr_arb2 u_arb (
    .req       ({d_valid, i_valid}),
    .last      (last_grant),
    .prio_mode (PRIO_MODE),
    .gnt_valid (arb_vld),
    .gnt_idx   (arb_idx)
  );

  // A completion in the expiry cycle takes precedence over the watchdog.
  always_comb begin
    req_done  = (state == ST_BUSY) && m_ready;
    req_tout  = (state == ST_BUSY) && !m_ready && (wdog == WDOG_FIRE);
    resp_data = m_ready ? m_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (arb_vld) state_d = ST_BUSY;
      ST_BUSY: if (req_done || req_tout) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= GNT_IBUS;
      last_grant <= GNT_IBUS;
      wdog       <= '0;
      m_valid    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      timeout    <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          wdog <= '0;
          if (arb_vld) begin
            gnt        <= arb_idx;
            last_grant <= arb_idx;
            m_valid    <= 1'b1;
            if (arb_idx == GNT_DBUS) begin
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_wstrb <= d_wstrb;
            end else begin
              m_addr  <= i_addr;
              m_wdata <= '0;
              m_wstrb <= {STRB_W{1'b0}};
            end
          end
        end
        ST_BUSY: begin
          wdog <= wdog + TIMEOUT_W'(1);
          if (req_done || req_tout) begin
            m_valid <= 1'b0;
            timeout <= req_tout;
            if (gnt == GNT_DBUS) begin
              d_ready <= 1'b1;
              d_rdata <= resp_data;
            end else begin
              i_ready <= 1'b1;
              i_rdata <= resp_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
